// File: rtl/mux_rr_registrado.sv
// ============================================================================
//  Module      : mux_rr_registrado
//  Description : N-channel, WIDTH-bit multiplexer with a registered output and
//                valid/ready handshakes on both sides. Two selection modes:
//                fixed channel (sel) or round-robin over valid channels.
//                One word per cycle; a drain and a load in the same cycle
//                produce back-to-back output with no bubble.
//  Ports       : clock    - rising-edge clock
//                reset    - asynchronous, active-high reset
//                d        - packed channel data, channel i at d[i*WIDTH +: WIDTH]
//                vin      - per-channel valid
//                rdy_in   - per-channel "word taken this cycle" (combinational)
//                mode     - 0 = fixed (sel), 1 = round-robin
//                sel      - channel index used in fixed mode
//                y        - registered output data
//                ch       - index of the channel that produced y
//                vout     - y/ch valid
//                rdy_out  - consumer ready
//                par      - parity (XOR reduction) of y, registered with y
//  Config      : MUX_RR_PARITY_EN - when defined, adds the par output and its
//                register; when undefined neither exists.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_registrado #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [N-1:0]       vin,
  output logic [N-1:0]       rdy_in,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   y,
  output logic [SELW-1:0]    ch,
`ifdef MUX_RR_PARITY_EN
  output logic               par,
`endif
  output logic               vout,
  input  logic               rdy_out
);

  // Registered state
  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_ch;
  logic             r_vout;
  logic [SELW-1:0]  r_ptr;

  // Combinational selection
  logic             w_free;
  logic             w_found;
  logic [SELW-1:0]  w_c;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;
  logic [SELW-1:0]  w_ptr_next;

  // The output register can take a new word when empty or being drained now.
  assign w_free = !r_vout || rdy_out;

  always_comb begin
    int w_idx;
    w_found = 1'b0;
    w_c     = '0;
    w_idx   = 0;
    if (!mode) begin
      // Out-of-range sel (only possible when N is not a power of two)
      // selects nothing.
      if (int'(sel) < N) begin
        w_found = vin[sel];
        w_c     = sel;
      end
    end else begin
      // Scan from the pointer upward, wrapping; the first valid channel wins.
      for (int k = 0; k < N; k++) begin
        w_idx = (int'(r_ptr) + k) % N;
        if (!w_found && vin[w_idx]) begin
          w_found = 1'b1;
          w_c     = w_idx[SELW-1:0];
        end
      end
    end
  end

  assign w_accept   = w_free && w_found;
  // w_c is always a legal index whenever w_found is set, so this read is
  // only consumed for valid channels.
  assign w_data     = d[int'(w_c)*WIDTH +: WIDTH];
  assign w_ptr_next = (w_c == SELW'(N - 1)) ? '0 : w_c + 1'b1;

  // One-hot handshake back to the producers; never high for an idle channel.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rdy
      assign rdy_in[gi] = w_accept && (w_c == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_y    <= '0;
      r_ch   <= '0;
      r_vout <= 1'b0;
      r_ptr  <= '0;
    end else begin
      if (w_accept) begin
        r_y    <= w_data;
        r_ch   <= w_c;
        r_vout <= 1'b1;
        // Fixed mode never disturbs the round-robin position.
        if (mode) begin
          r_ptr <= w_ptr_next;
        end
      end else if (rdy_out) begin
        // Drained with nothing to replace it: y and ch keep their values.
        r_vout <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_PARITY_EN
  logic r_par;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^w_data;
    end
  end

  assign par = r_par;
`endif

  assign y    = r_y;
  assign ch   = r_ch;
  assign vout = r_vout;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_registrado.sv
// ============================================================================
//  Module      : tb_mux_rr_registrado
//  Description : Self-checking bench for mux_rr_registrado (N=4, WIDTH=8).
//                Directed scenarios followed by random traffic, all compared
//                against a behavioural model of the mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_registrado;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic               clock;
  logic               reset;
  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       vin;
  logic [N-1:0]       rdy_in;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   y;
  logic [SELW-1:0]    ch;
  logic               vout;
  logic               rdy_out;
`ifdef MUX_RR_PARITY_EN
  logic               par;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [WIDTH-1:0] m_y;
  int               m_ch;
  logic             m_vout;
  int               m_ptr;
  logic             m_par;
  logic [N-1:0]     last_rdy;

  mux_rr_registrado #(.N(N), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .d       (d),
    .vin     (vin),
    .rdy_in  (rdy_in),
    .mode    (mode),
    .sel     (sel),
    .y       (y),
    .ch      (ch),
`ifdef MUX_RR_PARITY_EN
    .par     (par),
`endif
    .vout    (vout),
    .rdy_out (rdy_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chosen channel per the selection rules, -1 when none.
  function automatic int choose(input logic md, input int s, input logic [N-1:0] v, input int p);
    int order[N];
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++) order[k] = (p + k) % N;
    foreach (order[k]) if (v[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    m_y = '0; m_ch = 0; m_vout = 1'b0; m_ptr = 0; m_par = 1'b0;
  endtask

  task automatic check_outputs();
    check("y", 32'(y), 32'(m_y));
    check("ch", 32'(ch), 32'(m_ch));
    check("vout", 32'(vout), 32'(m_vout));
`ifdef MUX_RR_PARITY_EN
    check("par", 32'(par), 32'(m_par));
`endif
  endtask

  // Called right after an edge (+1) once inputs are driven: checks rdy_in,
  // crosses one edge, updates the model and checks the registered outputs.
  task automatic cycle();
    int c;
    logic free;
    logic [N-1:0] exp_rdy;
    #2;
    c = choose(mode, int'(sel), vin, m_ptr);
    free = !m_vout || rdy_out;
    exp_rdy = (free && c >= 0) ? N'(1 << c) : '0;
    last_rdy = rdy_in;
    check("rdy_in", 32'(rdy_in), 32'(exp_rdy));
    @(posedge clock);
    if (free && c >= 0) begin
      m_y = d[c*WIDTH +: WIDTH];
      m_ch = c;
      m_vout = 1'b1;
      m_par = ^m_y;
      if (mode) m_ptr = (c + 1) % N;
    end else if (rdy_out) begin
      m_vout = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_reset();
    vin = '0;
    cycle();
  endtask

  initial begin
    reset = 1'b1; d = '0; vin = '0; mode = 1'b0; sel = '0; rdy_out = 1'b0;
    model_reset();
    #12;
    check_outputs();
    reset = 1'b0;

    // 1. Reset mid-transfer with a word held
    mode = 1'b1; vin = 4'b1111; d = 32'h44332211; rdy_out = 1'b0;
    cycle();
    check("t1_vout_before", 32'(vout), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("t1_y_async", 32'(y), 32'd0);
    check("t1_vout_async", 32'(vout), 32'd0);
    check("t1_ch_async", 32'(ch), 32'd0);
    reset = 1'b0;
    vin = '0;
    cycle();

    // 2. Fixed mode, sel=2
    mode = 1'b0; sel = 2'd2; vin = 4'b0100; d = 32'h00A50000; rdy_out = 1'b1;
    cycle();
    check("t2_rdy_in", 32'(last_rdy), 32'h4);
    check("t2_y", 32'(y), 32'hA5);
    check("t2_ch", 32'(ch), 32'd2);
    check("t2_vout", 32'(vout), 32'd1);

    // 3. Fixed mode on an idle channel, then sweep sel
    sel = 2'd1; vin = 4'b0100;
    cycle();
    check("t3_rdy_none", 32'(last_rdy), 32'd0);
    check("t3_vout_low", 32'(vout), 32'd0);
    d = 32'h40302010; vin = 4'b1111;
    for (int s = 0; s < N; s++) begin
      sel = SELW'(s);
      cycle();
      check("t3_ch_follows_sel", 32'(ch), 32'(s));
      check("t3_y", 32'(y), 32'(8'h10 * (s + 1)));
    end

    // 4. Round-robin from ptr=0 with all channels valid
    do_reset();
    mode = 1'b1; vin = 4'b1111; rdy_out = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t4_rr_ch", 32'(ch), 32'(k % N));
      check("t4_rr_vout", 32'(vout), 32'd1);
    end

    // 5. Wrap/skip: bring ptr to 3, then single and split requests
    do_reset();
    mode = 1'b1; rdy_out = 1'b1; vin = 4'b0100;
    cycle();
    check("t5_setup_ch", 32'(ch), 32'd2);
    vin = 4'b0010;
    cycle();
    check("t5_skip_ch", 32'(ch), 32'd1);
    check("t5_ptr", 32'(m_ptr), 32'd2);
    vin = 4'b1001;
    cycle();
    check("t5_ch3", 32'(ch), 32'd3);
    cycle();
    check("t5_wrap_ch0", 32'(ch), 32'd0);

    // 6. Backpressure and release; every channel carries 8'h07
    d = {4{8'h07}}; vin = 4'b1111; rdy_out = 1'b1;
    cycle();
    rdy_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t6_frozen_rdy", 32'(last_rdy), 32'd0);
      check("t6_frozen_vout", 32'(vout), 32'd1);
    end
    rdy_out = 1'b1;
    cycle();
    check("t6_release_rdy", 32'(last_rdy != 0), 32'd1);
    check("t6_y", 32'(y), 32'h07);
`ifdef MUX_RR_PARITY_EN
    check("t6_par", 32'(par), 32'd1);
`endif

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      d       = $urandom;
      vin     = N'($urandom);
      mode    = 1'($urandom);
      sel     = SELW'($urandom);
      rdy_out = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
